ones_pattern_gen: RTL and testbench
===================================

Name: ones_pattern_gen

Overview:
Inverse of the popcount counter. Given a ones-count N (0-8) and a rotation offset R (0-7), it serially builds an 8-bit word containing exactly N ones, then rotates that word left by R. It is structured as an ASMD, with a controller FSM driving a shift/rotate datapath. It uses the same start/done handshake as the lab bit-counter, so the two can be chained for round-trip checking.

Parameters:
W, 8, pattern width in bits
CW, 4, count input width; must hold the value W
RW, 3, rotation input width; equals clog2(W)

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  asynchronous, active-low reset; 0 forces the idle state immediately
start  input  1  level request; sampled only in S_IDLE and S_DONE
count  input  CW  number of ones to generate; sampled when start is accepted
rot  input  RW  left-rotation amount; sampled when start is accepted
busy  output  1  high in S_FILL and S_ROT
done  output  1  high in S_DONE only
err  output  1  high when the accepted count was greater than W; holds until the next accepted start
pattern  output  W  generated word; registered

Behaviour:
- Reset (reset=0, asynchronous): state=S_IDLE, pattern=0, cnt_reg=0, rot_reg=0, busy=0, done=0, err=0.
- S_IDLE: if start=1, then:
  - pattern<=0;
  - cnt_reg<=min(count,W);
  - err<=(count>W);
  - rot_reg<=rot;
  - next state S_FILL.
  If start=0, all registers hold. pattern keeps the last result.
- S_FILL: if cnt_reg!=0, pattern<={pattern[W-2:0],1'b1} and cnt_reg<=cnt_reg-1, staying in S_FILL. If cnt_reg==0, go to S_ROT with no data change.
- S_ROT: if rot_reg!=0, pattern<={pattern[W-2:0],pattern[W-1]} and rot_reg<=rot_reg-1, staying in S_ROT. If rot_reg==0, go to S_DONE.
- S_DONE: done=1 and pattern is stable. If start=0, go to S_IDLE. If start stays 1, remain in S_DONE; no retrigger until start drops.
- Latency: count the start-accepting edge as edge 1. done rises after edge N'+R+3, where N'=min(count,W).
  - Example: N=3, R=0 gives done visible after edge 6.
- Inputs count and rot may change freely after acceptance; only the latched copies are used.
- Rotation is modular: a word of all ones (N=8) or all zeros (N=0) is unchanged by any R.
- Saturation: count in 9..15 is treated as 8, and err=1.
- Reset mid-operation (any state): immediate return to the reset values. No partial pattern survives.
- busy and done are never both high. Both are decoded combinationally from the state register.

Decomposition:
- Package ones_gen_pkg holds:
  - typedef enum logic [1:0] {S_IDLE, S_FILL, S_ROT, S_DONE} state_t;
  - localparams W=8, CW=4, RW=3.
- Sub-module ones_gen_datapath holds pattern, cnt_reg, rot_reg and err. It takes control signals load, fill, rotate and returns status cnt_is0 and rot_is0.
- The top module holds the state_t register and next-state/control logic only.

Test Plan:
- Release reset; start=1 with count=3, rot=0 for one cycle, then start=0 -> pattern=8'h07; done high after edge 6; busy high for edges 2-5; err=0.
- start with count=3, rot=2 -> pattern=8'h1C; done after edge 8.
- start with count=0, rot=5 -> pattern=8'h00; done after edge 8. Also count=8, rot=3 -> pattern=8'hFF, err=0.
- start with count=12, rot=1 -> saturates: pattern=8'hFF, err=1. A following start with count=1, rot=7 -> pattern=8'h80, err=0.
- Hold start=1 through completion -> stays in S_DONE with done=1 for 5+ cycles. Drop start -> S_IDLE next edge; pattern retained; done=0.
- Assert reset=0 mid-S_FILL (count=6, after 2 shifts) between clock edges -> pattern=0 and busy=0 immediately, without a clock edge. After release, a new run with count=2, rot=0 gives 8'h03.

Source files
------------

// File: rtl/ones_gen_pkg.sv
// Shared types and sizing for the ones-pattern generator.
// The generator is the inverse of the popcount bit-counter.
package ones_gen_pkg;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_ROT, S_DONE} state_t;

    localparam int W  = 8;
    localparam int CW = 4;
    localparam int RW = 3;

    // Pattern width expressed at count-input width, for saturation and error compares.
    localparam logic [CW-1:0] W_CNT = CW'(W);

endpackage

// File: rtl/ones_gen_datapath.sv
// Shift/rotate datapath: fills ones serially into the pattern, then rotates it left.
// It holds the latched count/rotation and the over-range error flag.
module ones_gen_datapath
    import ones_gen_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          fill,
    input  logic          rotate,
    input  logic [CW-1:0] count,
    input  logic [RW-1:0] rot,
    output logic [W-1:0]  pattern,
    output logic          err,
    output logic          cnt_is0,
    output logic          rot_is0
);

    logic [CW-1:0] cnt_reg;
    logic [RW-1:0] rot_reg;

    function automatic logic [CW-1:0] sat_count(input logic [CW-1:0] c);
        return (c > W_CNT) ? W_CNT : c;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pattern <= '0;
            cnt_reg <= '0;
            rot_reg <= '0;
            err     <= 1'b0;
        end else if (load) begin
            pattern <= '0;
            cnt_reg <= sat_count(count);
            err     <= (count > W_CNT);
            rot_reg <= rot;
        end else if (fill) begin
            pattern <= {pattern[W-2:0], 1'b1};
            cnt_reg <= cnt_reg - CW'(1);
        end else if (rotate) begin
            pattern <= {pattern[W-2:0], pattern[W-1]};
            rot_reg <= rot_reg - RW'(1);
        end
    end

    assign cnt_is0 = (cnt_reg == '0);
    assign rot_is0 = (rot_reg == '0);

endmodule

// File: rtl/ones_pattern_gen.sv
// Controller for the ones-pattern generator: start/done handshake FSM that
// sequences load, fill and rotate steps of the datapath.
module ones_pattern_gen
    import ones_gen_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] count,
    input  logic [RW-1:0] rot,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [W-1:0]  pattern
);

    state_t state;
    logic   load;
    logic   fill;
    logic   rotate;
    logic   cnt_is0;
    logic   rot_is0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start)   state <= S_FILL;
                S_FILL:  if (cnt_is0) state <= S_ROT;
                S_ROT:   if (rot_is0) state <= S_DONE;
                S_DONE:  if (!start)  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Terminal step of FILL/ROT moves on without touching data.
    assign load   = (state == S_IDLE) && start;
    assign fill   = (state == S_FILL) && !cnt_is0;
    assign rotate = (state == S_ROT)  && !rot_is0;

    assign busy = (state == S_FILL) || (state == S_ROT);
    assign done = (state == S_DONE);

    ones_gen_datapath u_datapath (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .fill    (fill),
        .rotate  (rotate),
        .count   (count),
        .rot     (rot),
        .pattern (pattern),
        .err     (err),
        .cnt_is0 (cnt_is0),
        .rot_is0 (rot_is0)
    );

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Directed self-checking bench for ones_pattern_gen with hand-computed patterns and latencies.
module tb_ones_pattern_gen;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] count;
    logic [2:0] rot;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] pattern;

    int vectors;
    int miscompares;

    ones_pattern_gen dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .count   (count),
        .rot     (rot),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .pattern (pattern)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept a start on edge 1, then expect done exactly after edge 'lat'.
    task automatic run(input logic [3:0] c, input logic [2:0] r, input logic hold,
                       input logic [7:0] exp_pat, input logic exp_err, input int lat);
        count = c;
        rot   = r;
        start = 1'b1;
        step();
        if (!hold) start = 1'b0;
        count = ~c;
        rot   = ~r;
        chk("err_at_accept", 8'(err), 8'(exp_err));
        for (int k = 1; k < lat; k++) begin
            chk("busy_running", 8'(busy), 8'h01);
            chk("done_running", 8'(done), 8'h00);
            step();
        end
        chk("done_at_latency", 8'(done), 8'h01);
        chk("busy_at_done", 8'(busy), 8'h00);
        chk("pattern", pattern, exp_pat);
        chk("err", 8'(err), 8'(exp_err));
        if (!hold) begin
            step();
            chk("done_after_idle", 8'(done), 8'h00);
            chk("pattern_retained", pattern, exp_pat);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b0;
        start = 1'b0;
        count = 4'd0;
        rot   = 3'd0;
        #12;
        chk("reset_pattern", pattern, 8'h00);
        chk("reset_busy", 8'(busy), 8'h00);
        chk("reset_done", 8'(done), 8'h00);
        chk("reset_err", 8'(err), 8'h00);
        reset = 1'b1;
        step();

        run(4'd3,  3'd0, 1'b0, 8'h07, 1'b0, 6);
        run(4'd3,  3'd2, 1'b0, 8'h1C, 1'b0, 8);
        run(4'd0,  3'd5, 1'b0, 8'h00, 1'b0, 8);
        run(4'd8,  3'd3, 1'b0, 8'hFF, 1'b0, 14);
        run(4'd12, 3'd1, 1'b0, 8'hFF, 1'b1, 12);
        run(4'd1,  3'd7, 1'b0, 8'h80, 1'b0, 11);

        // Start held high: parked in DONE until it drops.
        run(4'd2, 3'd1, 1'b1, 8'h06, 1'b0, 6);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("hold_done", 8'(done), 8'h01);
            chk("hold_busy", 8'(busy), 8'h00);
        end
        start = 1'b0;
        step();
        chk("release_done", 8'(done), 8'h00);
        chk("release_pattern", pattern, 8'h06);

        // Asynchronous reset in the middle of the fill phase.
        count = 4'd6;
        rot   = 3'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("mid_fill_pattern", pattern, 8'h03);
        chk("mid_fill_busy", 8'(busy), 8'h01);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_pattern", pattern, 8'h00);
        chk("async_rst_busy", 8'(busy), 8'h00);
        chk("async_rst_done", 8'(done), 8'h00);
        @(negedge clk);
        reset = 1'b1;
        step();
        run(4'd2, 3'd0, 1'b0, 8'h03, 1'b0, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
